// File: rtl/op_stack_file.sv
// rtl/op_stack_file.sv - parametrised operand stack with combinational TOS/NOS and sticky error flags
// One stack operation per clock; illegal ops leave storage and count untouched.
module op_stack_file #(
    parameter  int DBITS = 32,
    parameter  int DEPTH = 16,
    localparam int CBITS = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       op,
    input  logic [DBITS-1:0] din,
    input  logic             err_clr,
    output logic [DBITS-1:0] tos,
    output logic [DBITS-1:0] nos,
    output logic [CBITS-1:0] count,
    output logic             empty,
    output logic             full,
    output logic             op_ok,
    output logic             overflow,
    output logic             underflow
);

    localparam int IBITS = $clog2(DEPTH);

    typedef enum logic [2:0] {
        OP_NOP      = 3'd0,
        OP_PUSH     = 3'd1,
        OP_POP      = 3'd2,
        OP_POP2PUSH = 3'd3,
        OP_REPLACE  = 3'd4,
        OP_DUP      = 3'd5,
        OP_SWAP     = 3'd6,
        OP_CLEAR    = 3'd7
    } op_e;

    logic [DBITS-1:0] r_mem [DEPTH];
    logic [CBITS-1:0] r_count;
    logic             r_overflow;
    logic             r_underflow;

    op_e              w_op;
    logic [IBITS-1:0] w_idx_n;
    logic [IBITS-1:0] w_idx_tos;
    logic [IBITS-1:0] w_idx_nos;
    logic             w_ge1;
    logic             w_ge2;
    logic             w_full;
    logic [DBITS-1:0] w_mem_tos;
    logic [DBITS-1:0] w_mem_nos;

    logic             w_ok;
    logic             w_set_ovf;
    logic             w_set_unf;
    logic [CBITS-1:0] w_count_nxt;
    logic             w_we_a;
    logic [IBITS-1:0] w_wa_idx;
    logic [DBITS-1:0] w_wa_data;
    logic             w_we_b;
    logic [IBITS-1:0] w_wb_idx;
    logic [DBITS-1:0] w_wb_data;

    assign w_op = op_e'(op);

    // Low bits of count address the stack; at count==DEPTH the low bits wrap to 0,
    // so count-1 still lands on the top entry, and count itself is never written then.
    assign w_idx_n   = r_count[IBITS-1:0];
    assign w_idx_tos = w_idx_n - IBITS'(1);
    assign w_idx_nos = w_idx_n - IBITS'(2);

    assign w_ge1  = (r_count != '0);
    assign w_ge2  = (r_count > CBITS'(1));
    assign w_full = (r_count == CBITS'(DEPTH));

    assign w_mem_tos = r_mem[w_idx_tos];
    assign w_mem_nos = r_mem[w_idx_nos];

    always_comb begin
        w_ok        = 1'b1;
        w_set_ovf   = 1'b0;
        w_set_unf   = 1'b0;
        w_count_nxt = r_count;
        w_we_a      = 1'b0;
        w_wa_idx    = w_idx_n;
        w_wa_data   = din;
        w_we_b      = 1'b0;
        w_wb_idx    = w_idx_nos;
        w_wb_data   = w_mem_tos;
        case (w_op)
            OP_PUSH: begin
                if (w_full) begin
                    w_ok      = 1'b0;
                    w_set_ovf = 1'b1;
                end else begin
                    w_we_a      = 1'b1;
                    w_count_nxt = r_count + CBITS'(1);
                end
            end
            OP_POP: begin
                if (!w_ge1) begin
                    w_ok      = 1'b0;
                    w_set_unf = 1'b1;
                end else begin
                    w_count_nxt = r_count - CBITS'(1);
                end
            end
            OP_POP2PUSH: begin
                if (!w_ge2) begin
                    w_ok      = 1'b0;
                    w_set_unf = 1'b1;
                end else begin
                    w_we_a      = 1'b1;
                    w_wa_idx    = w_idx_nos;
                    w_count_nxt = r_count - CBITS'(1);
                end
            end
            OP_REPLACE: begin
                if (!w_ge1) begin
                    w_ok      = 1'b0;
                    w_set_unf = 1'b1;
                end else begin
                    w_we_a   = 1'b1;
                    w_wa_idx = w_idx_tos;
                end
            end
            OP_DUP: begin
                if (w_full) begin
                    w_ok      = 1'b0;
                    w_set_ovf = 1'b1;
                end else if (!w_ge1) begin
                    w_ok      = 1'b0;
                    w_set_unf = 1'b1;
                end else begin
                    w_we_a      = 1'b1;
                    w_wa_data   = w_mem_tos;
                    w_count_nxt = r_count + CBITS'(1);
                end
            end
            OP_SWAP: begin
                if (!w_ge2) begin
                    w_ok      = 1'b0;
                    w_set_unf = 1'b1;
                end else begin
                    w_we_a    = 1'b1;
                    w_wa_idx  = w_idx_tos;
                    w_wa_data = w_mem_nos;
                    w_we_b    = 1'b1;
                    w_wb_idx  = w_idx_nos;
                    w_wb_data = w_mem_tos;
                end
            end
            OP_CLEAR: begin
                w_count_nxt = '0;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_count     <= w_count_nxt;
            // A new error in the same cycle as err_clr keeps that flag set.
            r_overflow  <= w_set_ovf | (r_overflow  & ~err_clr);
            r_underflow <= w_set_unf | (r_underflow & ~err_clr);
        end
    end

    // Storage is not reset; entries above count are masked on the outputs.
    always_ff @(posedge clk) begin
        if (w_we_a) begin
            r_mem[w_wa_idx] <= w_wa_data;
        end
        if (w_we_b) begin
            r_mem[w_wb_idx] <= w_wb_data;
        end
    end

    assign tos       = w_ge1 ? w_mem_tos : '0;
    assign nos       = w_ge2 ? w_mem_nos : '0;
    assign count     = r_count;
    assign empty     = ~w_ge1;
    assign full      = w_full;
    assign op_ok     = w_ok;
    assign overflow  = r_overflow;
    assign underflow = r_underflow;

endmodule

// File: tb/tb_op_stack_file.sv
// tb/tb_op_stack_file.sv - queue-model bench for op_stack_file with directed and random ops
module tb_op_stack_file;

    localparam int DBITS = 8;
    localparam int DEPTH = 4;
    localparam int CBITS = 3;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [2:0]       op = 3'd0;
    logic [DBITS-1:0] din = '0;
    logic             err_clr = 1'b0;
    logic [DBITS-1:0] tos;
    logic [DBITS-1:0] nos;
    logic [CBITS-1:0] count;
    logic             empty;
    logic             full;
    logic             op_ok;
    logic             overflow;
    logic             underflow;

    int n_tests = 0;
    int n_fail  = 0;

    logic [DBITS-1:0] m_stk [$];
    bit               m_ovf = 1'b0;
    bit               m_unf = 1'b0;
    logic             last_ok;

    always #5 clk = ~clk;

    op_stack_file #(.DBITS(DBITS), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .op        (op),
        .din       (din),
        .err_clr   (err_clr),
        .tos       (tos),
        .nos       (nos),
        .count     (count),
        .empty     (empty),
        .full      (full),
        .op_ok     (op_ok),
        .overflow  (overflow),
        .underflow (underflow)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit m_ovf_err(input logic [2:0] o, input int n);
        return (o == 3'd1 || o == 3'd5) && n == DEPTH;
    endfunction

    function automatic bit m_unf_err(input logic [2:0] o, input int n);
        return ((o == 3'd2 || o == 3'd4 || o == 3'd5) && n == 0) ||
               ((o == 3'd3 || o == 3'd6) && n < 2);
    endfunction

    always @(posedge clk or posedge reset) begin
        int n;
        bit eo;
        bit eu;
        logic [DBITS-1:0] t;
        if (reset) begin
            m_stk.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            n  = m_stk.size();
            eo = m_ovf_err(op, n);
            eu = m_unf_err(op, n);
            if (!eo && !eu) begin
                case (op)
                    3'd1: m_stk.push_back(din);
                    3'd2: void'(m_stk.pop_back());
                    3'd3: begin
                        void'(m_stk.pop_back());
                        void'(m_stk.pop_back());
                        m_stk.push_back(din);
                    end
                    3'd4: m_stk[n-1] = din;
                    3'd5: begin
                        t = m_stk[n-1];
                        m_stk.push_back(t);
                    end
                    3'd6: begin
                        t = m_stk[n-1];
                        m_stk[n-1] = m_stk[n-2];
                        m_stk[n-2] = t;
                    end
                    3'd7: m_stk.delete();
                    default: ;
                endcase
            end
            m_ovf = eo | (m_ovf & !err_clr);
            m_unf = eu | (m_unf & !err_clr);
        end
    end

    always @(negedge clk) begin
        int n;
        logic [DBITS-1:0] e_tos;
        logic [DBITS-1:0] e_nos;
        n     = m_stk.size();
        e_tos = (n >= 1) ? m_stk[n-1] : '0;
        e_nos = (n >= 2) ? m_stk[n-2] : '0;
        chk("count", 32'(count), 32'(n));
        chk("tos", 32'(tos), 32'(e_tos));
        chk("nos", 32'(nos), 32'(e_nos));
        chk("empty", 32'(empty), 32'(n == 0));
        chk("full", 32'(full), 32'(n == DEPTH));
        chk("op_ok", 32'(op_ok), 32'(!(m_ovf_err(op, n) || m_unf_err(op, n))));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("underflow", 32'(underflow), 32'(m_unf));
    end

    task automatic step(input logic [2:0] o, input logic [DBITS-1:0] d, input logic c);
        op      = o;
        din     = d;
        err_clr = c;
        #1 last_ok = op_ok;
        @(posedge clk);
        #1;
        op      = 3'd0;
        din     = '0;
        err_clr = 1'b0;
    endtask

    initial begin
        logic [2:0] ro;
        repeat (2) @(posedge clk);
        #1;
        chk("lit_rst_count", 32'(count), 0);
        chk("lit_rst_empty", 32'(empty), 1);
        chk("lit_rst_full", 32'(full), 0);
        chk("lit_rst_tos", 32'(tos), 0);
        chk("lit_rst_nos", 32'(nos), 0);
        chk("lit_rst_ovf", 32'(overflow), 0);
        reset = 1'b0;

        step(3'd1, 8'h11, 0); step(3'd1, 8'h22, 0); step(3'd1, 8'h33, 0); step(3'd1, 8'h44, 0);
        chk("lit_fill_count", 32'(count), 4);
        chk("lit_fill_full", 32'(full), 1);
        chk("lit_fill_tos", 32'(tos), 32'h44);
        chk("lit_fill_nos", 32'(nos), 32'h33);
        step(3'd1, 8'h55, 0);
        chk("lit_push5_ok", 32'(last_ok), 0);
        chk("lit_push5_count", 32'(count), 4);
        chk("lit_push5_tos", 32'(tos), 32'h44);
        chk("lit_push5_ovf", 32'(overflow), 1);

        step(3'd7, 8'h00, 1);
        step(3'd1, 8'h11, 0); step(3'd1, 8'h22, 0);
        step(3'd3, 8'h33, 0);
        chk("lit_p2p_count", 32'(count), 1);
        chk("lit_p2p_tos", 32'(tos), 32'h33);
        chk("lit_p2p_nos", 32'(nos), 0);
        step(3'd6, 8'h00, 0);
        chk("lit_swap1_ok", 32'(last_ok), 0);
        chk("lit_swap1_unf", 32'(underflow), 1);
        chk("lit_swap1_tos", 32'(tos), 32'h33);

        step(3'd7, 8'h00, 1);
        step(3'd1, 8'hA0, 0); step(3'd1, 8'hB0, 0);
        step(3'd6, 8'h00, 0);
        chk("lit_swap_tos", 32'(tos), 32'hA0);
        chk("lit_swap_nos", 32'(nos), 32'hB0);
        step(3'd5, 8'h00, 0);
        chk("lit_dup_count", 32'(count), 3);
        chk("lit_dup_tos", 32'(tos), 32'hA0);
        chk("lit_dup_nos", 32'(nos), 32'hA0);
        step(3'd4, 8'h5C, 0);
        chk("lit_repl_tos", 32'(tos), 32'h5C);
        chk("lit_repl_count", 32'(count), 3);

        step(3'd7, 8'h00, 0);
        step(3'd2, 8'h00, 0);
        chk("lit_pop0_unf", 32'(underflow), 1);
        chk("lit_pop0_count", 32'(count), 0);
        chk("lit_pop0_empty", 32'(empty), 1);
        step(3'd2, 8'h00, 1);
        chk("lit_clrpop_unf", 32'(underflow), 1);
        step(3'd0, 8'h00, 1);
        chk("lit_clrnop_unf", 32'(underflow), 0);

        step(3'd2, 8'h00, 0);
        step(3'd1, 8'h01, 0); step(3'd1, 8'h02, 0); step(3'd1, 8'h03, 0);
        step(3'd7, 8'h00, 0);
        chk("lit_clear_count", 32'(count), 0);
        chk("lit_clear_tos", 32'(tos), 0);
        chk("lit_clear_nos", 32'(nos), 0);
        chk("lit_clear_unf", 32'(underflow), 1);
        step(3'd1, 8'h07, 0);
        chk("lit_stale_tos", 32'(tos), 7);
        chk("lit_stale_nos", 32'(nos), 0);

        step(3'd1, 8'h01, 0); step(3'd1, 8'h02, 0); step(3'd1, 8'h03, 0);
        step(3'd1, 8'h04, 0);
        step(3'd2, 8'h00, 0);
        chk("lit_pre_rst_count", 32'(count), 3);
        chk("lit_pre_rst_ovf", 32'(overflow), 1);
        #2 reset = 1'b1;
        #1;
        chk("lit_arst_count", 32'(count), 0);
        chk("lit_arst_ovf", 32'(overflow), 0);
        chk("lit_arst_tos", 32'(tos), 0);
        #1 reset = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                #1 reset = 1'b1;
                #1 reset = 1'b0;
            end
            ro = 3'($urandom_range(0, 6));
            if ($urandom_range(0, 19) == 0) ro = 3'd7;
            step(ro, 8'($urandom), ($urandom_range(0, 7) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
